uart_pinbus_ctrl: RTL and testbench

Command sequencer between the UART tapeout pin bus and the UART datapath's TX/RX FIFOs and baud generator. It accepts one 2-bit command per valid/ready handshake and performs the matching operation: write a byte into the TX FIFO, read a byte from the RX FIFO, clear both FIFOs, or load a baud rate. It owns direction control of the shared 8-bit data pins and keeps sticky overflow/underflow status.

---
 rtl/uart_pinbus_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_pinbus_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_pinbus_ctrl.sv
// uart_pinbus_ctrl: pin-bus command sequencer driving the UART TX/RX FIFOs,
// baud divisor and data-pin direction, with sticky overflow/underflow flags.
module uart_pinbus_ctrl #(
    parameter logic [15:0] DefaultRate = 16'd5207,
    parameter logic [15:0] Rate1       = 16'd16384,
    parameter logic [15:0] Rate2       = 16'd34816,
    parameter logic [15:0] Rate3       = 16'd53248,
    parameter int          HoldCycles  = 4,
    parameter int          ClearCycles = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd,
    output logic        cmd_ready,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        txf_wen,
    output logic [7:0]  txf_wdata,
    input  logic        txf_full,
    output logic        rxf_ren,
    input  logic [7:0]  rxf_rdata,
    input  logic        rxf_empty,
    input  logic        tx_busy,
    output logic        fifo_clear,
    output logic [15:0] rate,
    output logic        rate_load,
    output logic        cmd_err,
    output logic        ovf,
    output logic        udf
);
    typedef enum logic [2:0] {IDLE, WR_ACK, RD_HOLD, CLR_WAIT, CLR_PULSE} state_t;
    localparam logic [1:0] C_SET_RATE = 2'b00, C_WRITE = 2'b01, C_READ = 2'b10, C_CLEAR = 2'b11;

    state_t      r_state, w_state;
    logic [7:0]  r_cnt, w_cnt;
    logic [7:0]  r_data_out, w_data_out, r_txf_wdata, w_txf_wdata;
    logic [15:0] r_rate, w_rate;
    logic        r_data_oe, w_data_oe, r_txf_wen, w_txf_wen, r_rxf_ren, w_rxf_ren;
    logic        r_fifo_clear, w_fifo_clear, r_rate_load, w_rate_load;
    logic        r_cmd_err, w_cmd_err, r_ovf, w_ovf, r_udf, w_udf;
    logic        w_accept;
    logic [15:0] w_rate_sel;

    assign cmd_ready  = (r_state == IDLE);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_rate_sel = data_in[1] ? (data_in[0] ? Rate3 : Rate2) : (data_in[0] ? Rate1 : DefaultRate);

    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_data_out   = r_data_out;
        w_data_oe    = r_data_oe;
        w_txf_wen    = 1'b0;
        w_txf_wdata  = r_txf_wdata;
        w_rxf_ren    = 1'b0;
        w_fifo_clear = r_fifo_clear;
        w_rate       = r_rate;
        w_rate_load  = 1'b0;
        w_cmd_err    = 1'b0;
        w_ovf        = r_ovf;
        w_udf        = r_udf;
        case (r_state)
            IDLE: if (w_accept) begin
                case (cmd)
                    C_SET_RATE: begin
                        w_rate      = w_rate_sel;
                        w_rate_load = 1'b1;
                    end
                    C_WRITE: if (txf_full) begin
                        w_cmd_err = 1'b1;
                        w_ovf     = 1'b1;
                    end else begin
                        w_txf_wdata = data_in;
                        w_txf_wen   = 1'b1;
                        w_state     = WR_ACK;
                    end
                    C_READ: if (rxf_empty) begin
                        w_cmd_err = 1'b1;
                        w_udf     = 1'b1;
                    end else begin
                        w_data_out = rxf_rdata;
                        w_rxf_ren  = 1'b1;
                        w_data_oe  = 1'b1;
                        w_cnt      = 8'(HoldCycles - 1);
                        w_state    = RD_HOLD;
                    end
                    C_CLEAR: w_state = CLR_WAIT;
                    default: w_state = IDLE;
                endcase
            end
            WR_ACK: w_state = IDLE;
            RD_HOLD: if (r_cnt == 8'd0) begin
                w_data_oe  = 1'b0;
                w_data_out = 8'h00;
                w_state    = IDLE;
            end else begin
                w_cnt = r_cnt - 8'd1;
            end
            // Never times out: the clear must not cut a frame the transmitter is shifting.
            CLR_WAIT: if (!tx_busy) begin
                w_fifo_clear = 1'b1;
                w_cnt        = 8'(ClearCycles - 1);
                w_ovf        = 1'b0;
                w_udf        = 1'b0;
                w_state      = CLR_PULSE;
            end
            CLR_PULSE: if (r_cnt == 8'd0) begin
                w_fifo_clear = 1'b0;
                w_state      = IDLE;
            end else begin
                w_cnt = r_cnt - 8'd1;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 8'd0;
            r_data_out   <= 8'h00;
            r_data_oe    <= 1'b0;
            r_txf_wen    <= 1'b0;
            r_txf_wdata  <= 8'h00;
            r_rxf_ren    <= 1'b0;
            r_fifo_clear <= 1'b0;
            r_rate       <= DefaultRate;
            r_rate_load  <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_ovf        <= 1'b0;
            r_udf        <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_data_out   <= w_data_out;
            r_data_oe    <= w_data_oe;
            r_txf_wen    <= w_txf_wen;
            r_txf_wdata  <= w_txf_wdata;
            r_rxf_ren    <= w_rxf_ren;
            r_fifo_clear <= w_fifo_clear;
            r_rate       <= w_rate;
            r_rate_load  <= w_rate_load;
            r_cmd_err    <= w_cmd_err;
            r_ovf        <= w_ovf;
            r_udf        <= w_udf;
        end
    end

    assign data_out   = r_data_out;
    assign data_oe    = r_data_oe;
    assign txf_wen    = r_txf_wen;
    assign txf_wdata  = r_txf_wdata;
    assign rxf_ren    = r_rxf_ren;
    assign fifo_clear = r_fifo_clear;
    assign rate       = r_rate;
    assign rate_load  = r_rate_load;
    assign cmd_err    = r_cmd_err;
    assign ovf        = r_ovf;
    assign udf        = r_udf;
endmodule

// File: tb/tb_uart_pinbus_ctrl.sv
// tb_uart_pinbus_ctrl: directed vector table, reset-abort sequences and a
// randomized run against an operation-level reference model.
module tb_uart_pinbus_ctrl;
    localparam int HOLD = 4;
    localparam int CLRN = 2;

    logic        clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, txf_full = 1'b0, rxf_empty = 1'b1, tx_busy = 1'b0;
    logic [1:0]  cmd = 2'd0;
    logic [7:0]  data_in = 8'h00, rxf_rdata = 8'h00;
    logic        cmd_ready, data_oe, txf_wen, rxf_ren, fifo_clear, rate_load, cmd_err, ovf, udf;
    logic [7:0]  data_out, txf_wdata;
    logic [15:0] rate;
    logic [8:0]  ctl;

    always #5 clk = ~clk;

    uart_pinbus_ctrl dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .txf_wen(txf_wen),
        .txf_wdata(txf_wdata), .txf_full(txf_full), .rxf_ren(rxf_ren), .rxf_rdata(rxf_rdata),
        .rxf_empty(rxf_empty), .tx_busy(tx_busy), .fifo_clear(fifo_clear), .rate(rate),
        .rate_load(rate_load), .cmd_err(cmd_err), .ovf(ovf), .udf(udf)
    );

    // ctl bit order: ready, wen, ren, oe, clear, rate_load, err, ovf, udf
    assign ctl = {cmd_ready, txf_wen, rxf_ren, data_oe, fifo_clear, rate_load, cmd_err, ovf, udf};

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, v, input logic [1:0] c, input logic [7:0] d,
                         input logic f, e, b, input logic [7:0] rd);
        reset = r; cmd_valid = v; cmd = c; data_in = d;
        txf_full = f; rxf_empty = e; tx_busy = b; rxf_rdata = rd;
    endtask

    typedef struct {
        logic rst, vld; logic [1:0] cmd; logic [7:0] din; logic full, empty, busy; logic [7:0] rdata;
        logic [8:0] ctl; logic [7:0] wdata, dout; logic [15:0] rate;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic r, v, input logic [1:0] c, input logic [7:0] d,
                       input logic f, e, b, input logic [7:0] rd,
                       input logic [8:0] k, input logic [7:0] wd, dout, input logic [15:0] rt);
        vec_t x;
        x.rst = r; x.vld = v; x.cmd = c; x.din = d; x.full = f; x.empty = e; x.busy = b; x.rdata = rd;
        x.ctl = k; x.wdata = wd; x.dout = dout; x.rate = rt;
        vecs.push_back(x);
    endtask

    function automatic logic [15:0] rate_of(input logic [1:0] s);
        return s == 2'd0 ? 16'd5207 : s == 2'd1 ? 16'd16384 : s == 2'd2 ? 16'd34816 : 16'd53248;
    endfunction

    // Reference model: each accepted operation expands into a list of output frames
    // presented on the following edges; an empty list means the controller is idle.
    typedef struct packed {logic wen, ren, oe, clr; logic [7:0] dout;} frm_t;
    frm_t        fq[$];
    logic        m_busy, m_wait, m_wen, m_ren, m_oe, m_clr, m_rld, m_err, m_ovf, m_udf;
    logic [7:0]  m_wdata, m_dout;
    logic [15:0] m_rate;

    task automatic model_step(input logic r, v, input logic [1:0] c, input logic [7:0] d,
                              input logic f, e, b, input logic [7:0] rd);
        frm_t fr;
        logic was_busy;
        fr = '0;
        m_rld = 1'b0; m_err = 1'b0;
        if (r) begin
            fq.delete();
            m_busy = 1'b0; m_wait = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
            m_wdata = 8'h00; m_rate = 16'd5207;
        end else begin
            was_busy = m_busy;
            m_busy = 1'b0;
            if (m_wait) begin
                m_busy = 1'b1;
                if (!b) begin
                    m_wait = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
                    fr.clr = 1'b1;
                    repeat (CLRN - 1) fq.push_back(fr);
                end
            end else if (fq.size() > 0) begin
                fr = fq.pop_front();
                m_busy = 1'b1;
            end else if (!was_busy && v) begin
                case (c)
                    2'd0: begin m_rate = rate_of(d[1:0]); m_rld = 1'b1; end
                    2'd1: if (f) begin m_err = 1'b1; m_ovf = 1'b1; end
                          else begin fr.wen = 1'b1; m_wdata = d; m_busy = 1'b1; end
                    2'd2: if (e) begin m_err = 1'b1; m_udf = 1'b1; end
                          else begin
                              fr.oe = 1'b1; fr.dout = rd; m_busy = 1'b1;
                              repeat (HOLD - 1) fq.push_back(fr);
                              fr.ren = 1'b1;
                          end
                    default: begin m_wait = 1'b1; m_busy = 1'b1; end
                endcase
            end
        end
        {m_wen, m_ren, m_oe, m_clr, m_dout} = fr;
    endtask

    initial begin
        // rst vld cmd din full empty busy rdata | ctl wdata dout rate
        add(1, 0, 2'd0, 8'h00, 0, 1, 0, 8'h00, 9'b100000000, 8'h00, 8'h00, 16'd5207);
        add(0, 1, 2'd0, 8'h02, 0, 1, 0, 8'h00, 9'b100001000, 8'h00, 8'h00, 16'd34816);
        add(0, 1, 2'd0, 8'h00, 0, 1, 0, 8'h00, 9'b100001000, 8'h00, 8'h00, 16'd5207);
        add(0, 0, 2'd0, 8'h00, 0, 1, 0, 8'h00, 9'b100000000, 8'h00, 8'h00, 16'd5207);
        add(0, 1, 2'd1, 8'hA5, 0, 1, 0, 8'h00, 9'b010000000, 8'hA5, 8'h00, 16'd5207);
        add(0, 1, 2'd1, 8'h3C, 0, 1, 0, 8'h00, 9'b100000000, 8'hA5, 8'h00, 16'd5207);
        add(0, 1, 2'd1, 8'h3C, 0, 1, 0, 8'h00, 9'b010000000, 8'h3C, 8'h00, 16'd5207);
        add(0, 0, 2'd1, 8'h00, 0, 1, 0, 8'h00, 9'b100000000, 8'h3C, 8'h00, 16'd5207);
        add(0, 1, 2'd1, 8'h77, 1, 1, 0, 8'h00, 9'b100000110, 8'h3C, 8'h00, 16'd5207);
        add(0, 1, 2'd3, 8'h00, 0, 1, 1, 8'h00, 9'b000000010, 8'h3C, 8'h00, 16'd5207);
        for (int i = 0; i < 4; i++)
            add(0, 0, 2'd0, 8'h00, 0, 1, 1, 8'h00, 9'b000000010, 8'h3C, 8'h00, 16'd5207);
        add(0, 0, 2'd0, 8'h00, 0, 1, 0, 8'h00, 9'b000010000, 8'h3C, 8'h00, 16'd5207);
        add(0, 0, 2'd0, 8'h00, 0, 1, 0, 8'h00, 9'b000010000, 8'h3C, 8'h00, 16'd5207);
        add(0, 0, 2'd0, 8'h00, 0, 1, 0, 8'h00, 9'b100000000, 8'h3C, 8'h00, 16'd5207);
        add(0, 1, 2'd2, 8'h00, 0, 0, 0, 8'h5A, 9'b001100000, 8'h3C, 8'h5A, 16'd5207);
        add(0, 1, 2'd1, 8'h11, 0, 0, 0, 8'hFF, 9'b000100000, 8'h3C, 8'h5A, 16'd5207);
        add(0, 1, 2'd3, 8'h00, 0, 0, 0, 8'hFF, 9'b000100000, 8'h3C, 8'h5A, 16'd5207);
        add(0, 1, 2'd0, 8'h03, 0, 0, 0, 8'hFF, 9'b000100000, 8'h3C, 8'h5A, 16'd5207);
        add(0, 1, 2'd1, 8'h22, 0, 0, 0, 8'hFF, 9'b100000000, 8'h3C, 8'h00, 16'd5207);
        add(0, 1, 2'd2, 8'h00, 0, 1, 0, 8'h00, 9'b100000101, 8'h3C, 8'h00, 16'd5207);
        add(0, 0, 2'd0, 8'h00, 0, 1, 0, 8'h00, 9'b100000001, 8'h3C, 8'h00, 16'd5207);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].cmd, vecs[i].din, vecs[i].full, vecs[i].empty,
                  vecs[i].busy, vecs[i].rdata);
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].ctl));
            chk($sformatf("vec%0d_wdata", i), 32'(txf_wdata), 32'(vecs[i].wdata));
            chk($sformatf("vec%0d_dout", i), 32'(data_out), 32'(vecs[i].dout));
            chk($sformatf("vec%0d_rate", i), 32'(rate), 32'(vecs[i].rate));
        end

        // Reset while the read byte is being held on the pins.
        drive(0, 1, 2'd0, 8'h03, 0, 1, 0, 8'h00);
        @(negedge clk);
        chk("sr3_rate", 32'(rate), 32'd53248);
        drive(0, 1, 2'd2, 8'h00, 0, 0, 0, 8'hC3);
        @(negedge clk);
        chk("rdh_start", 32'({data_oe, data_out}), 32'({1'b1, 8'hC3}));
        drive(0, 0, 2'd0, 8'h00, 0, 1, 0, 8'h00);
        @(negedge clk);
        chk("rdh_mid", 32'({cmd_ready, data_oe, data_out}), 32'({1'b0, 1'b1, 8'hC3}));
        #2 reset = 1'b1;
        #1 chk("rst_rd", 32'({cmd_ready, data_oe, data_out, rate}), 32'({1'b1, 1'b0, 8'h00, 16'd5207}));
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_rd_quiet", 32'({txf_wen, rxf_ren, data_oe, fifo_clear, cmd_ready}), 32'(5'b00001));
        end

        // Reset while fifo_clear is asserted.
        drive(0, 1, 2'd0, 8'h01, 0, 1, 0, 8'h00);
        @(negedge clk);
        chk("sr1_rate", 32'(rate), 32'd16384);
        drive(0, 1, 2'd3, 8'h00, 0, 1, 0, 8'h00);
        @(negedge clk);
        chk("clrw_rdy", 32'({cmd_ready, fifo_clear}), 32'(2'b00));
        drive(0, 0, 2'd0, 8'h00, 0, 1, 0, 8'h00);
        @(negedge clk);
        chk("clrp_on", 32'({cmd_ready, fifo_clear}), 32'(2'b01));
        #2 reset = 1'b1;
        #1 chk("rst_clr", 32'({cmd_ready, fifo_clear, rate}), 32'({1'b1, 1'b0, 16'd5207}));
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_clr_quiet", 32'({txf_wen, rxf_ren, data_oe, fifo_clear, cmd_ready}), 32'(5'b00001));
        end

        // Randomized run against the reference model.
        for (int i = 0; i < 2000; i++) begin
            logic r, v, f, e, b;
            logic [1:0] c;
            logic [7:0] d, rd;
            r  = (i == 0) || ($urandom_range(0, 99) == 0);
            v  = $urandom_range(0, 9) < 6;
            c  = 2'($urandom);
            d  = 8'($urandom);
            f  = $urandom_range(0, 9) < 3;
            e  = $urandom_range(0, 9) < 3;
            b  = $urandom_range(0, 9) < 6;
            rd = 8'($urandom);
            drive(r, v, c, d, f, e, b, rd);
            model_step(r, v, c, d, f, e, b, rd);
            @(negedge clk);
            chk("rand_ctl", 32'(ctl), 32'({!m_busy, m_wen, m_ren, m_oe, m_clr, m_rld, m_err, m_ovf, m_udf}));
            chk("rand_wdata", 32'(txf_wdata), 32'(m_wdata));
            chk("rand_dout", 32'(data_out), 32'(m_dout));
            chk("rand_rate", 32'(rate), 32'(m_rate));
            chk("rand_excl", 32'($countones({txf_wen, rxf_ren, fifo_clear}) <= 1), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
